// File: rtl/id_hazard_unit_pkg.sv
// rtl/id_hazard_unit_pkg.sv - shared encodings for the decode-stage hazard unit
package id_hazard_unit_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         SEL_RF   = 0;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-source youngest-producer match, forward select and data mux
module hazard_src_match
    import id_hazard_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NFWD       = 3,
    parameter int LATE_SLACK = 1,
    parameter int SELW       = $clog2(NFWD + 1)
) (
    input  logic [4:0]         src,
    input  logic [XLEN-1:0]    rdata,
    input  logic [NFWD*5-1:0]  fwd_dest,
    input  logic [NFWD-1:0]    fwd_wen,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]    val,
    output logic [SELW-1:0]    sel,
    output logic               pend,
    output logic               pend_young
);

    logic            hit;
    logic            win_ready;
    logic            win_young;
    logic [SELW-1:0] win_sel;
    logic [XLEN-1:0] win_data;

    // Walk oldest to youngest so the lowest matching index overrides the rest.
    always_comb begin
        hit       = 1'b0;
        win_ready = 1'b0;
        win_young = 1'b0;
        win_sel   = SELW'(SEL_RF);
        win_data  = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_wen[i] && (fwd_dest[5*i +: 5] == src) && (src != REG_ZERO)) begin
                hit       = 1'b1;
                win_ready = fwd_ready[i];
                win_young = (i < LATE_SLACK);
                win_sel   = SELW'(i + 1);
                win_data  = fwd_data[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        sel        = (hit && win_ready) ? win_sel : SELW'(SEL_RF);
        val        = (hit && win_ready) ? win_data : rdata;
        pend       = hit && !win_ready;
        pend_young = hit && !win_ready && win_young;
    end

endmodule

// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - ID-stage operand forwarding, hazard stall, MDU busy tracking and stall counter
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NFWD       = 3,
    parameter int LATE_SLACK = 1,
    parameter int MDU_LAT    = 0,
    parameter int SELW       = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_early_rs,
    input  logic                 id_early_rt,
    input  logic [XLEN-1:0]      id_rdata_rs,
    input  logic [XLEN-1:0]      id_rdata_rt,
    input  logic [NFWD*5-1:0]    fwd_dest,
    input  logic [NFWD-1:0]      fwd_wen,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 id_hilo_access,
    input  logic                 id_mdu_start,
    input  logic                 mdu_done,
    output logic                 stall,
    output logic [XLEN-1:0]      rs_val,
    output logic [XLEN-1:0]      rt_val,
    output logic [SELW-1:0]      rs_fwd_sel,
    output logic [SELW-1:0]      rt_fwd_sel,
    output logic                 mdu_busy,
    output logic [31:0]          stall_cnt
);

    localparam int CNTW = 32;

    logic rs_pend, rs_pend_young, rt_pend, rt_pend_young;
    logic rs_stall, rt_stall, mdu_stall, start_ok;

    mdu_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    hazard_src_match #(.XLEN(XLEN), .NFWD(NFWD), .LATE_SLACK(LATE_SLACK), .SELW(SELW)) u_rs (
        .src(id_rs), .rdata(id_rdata_rs), .fwd_dest(fwd_dest), .fwd_wen(fwd_wen),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data), .val(rs_val), .sel(rs_fwd_sel),
        .pend(rs_pend), .pend_young(rs_pend_young)
    );

    hazard_src_match #(.XLEN(XLEN), .NFWD(NFWD), .LATE_SLACK(LATE_SLACK), .SELW(SELW)) u_rt (
        .src(id_rt), .rdata(id_rdata_rt), .fwd_dest(fwd_dest), .fwd_wen(fwd_wen),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data), .val(rt_val), .sel(rt_fwd_sel),
        .pend(rt_pend), .pend_young(rt_pend_young)
    );

    // An operand needed in ID cannot tolerate any pending producer; EX consumers only the young ones.
    always_comb begin
        rs_stall  = id_early_rs ? rs_pend : (id_use_rs && rs_pend_young);
        rt_stall  = id_early_rt ? rt_pend : (id_use_rt && rt_pend_young);
        mdu_busy  = (state_q == MDU_BUSY);
        mdu_stall = mdu_busy && id_valid && (id_hilo_access || id_mdu_start);
        stall     = id_valid && !flush && (rs_stall || rt_stall || mdu_stall);
        start_ok  = id_valid && id_mdu_start && !stall && !flush && (state_q == MDU_IDLE);
        stall_cnt = stall_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        case (state_q)
            MDU_IDLE: begin
                if (start_ok) begin
                    state_d = MDU_BUSY;
                    cnt_d   = (MDU_LAT > 0) ? CNTW'(MDU_LAT - 1) : '0;
                end
            end
            MDU_BUSY: begin
                if (MDU_LAT > 0) begin
                    if (cnt_q == '0) state_d = MDU_IDLE;
                    else             cnt_d   = cnt_q - CNTW'(1);
                end else if (mdu_done) begin
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/id_hazard_unit.md
Name: id_hazard_unit

Overview:
- Parametrised decode-stage hazard and forwarding unit for the static 5-stage MIPS pipeline.
- Sits beside the decoder in ID and generalises branch/JR operand forwarding to NFWD downstream stages.
- Separates early consumers (branch/JR, operand needed in ID) from late consumers (ALU, operand needed in EX).
- Also owns a multi-cycle MDU busy tracker (fixed-latency or done-handshake mode) and a stall performance counter.

Parameters:
- XLEN, 32, operand data width.
- NFWD, 3, number of forwarding stages; index 0 is the youngest (EX), NFWD-1 the oldest (WB).
- LATE_SLACK, 1, late consumers stall only on not-ready producers in stages with index < LATE_SLACK.
- MDU_LAT, 0, 0 = MDU busy until mdu_done; N>0 = busy for exactly N cycles after start.
- SELW, $clog2(NFWD+1), width of the forward-select outputs.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (exception/ERET)
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt  in  5 each  source register numbers
- id_use_rs, id_use_rt  in  1 each  operand read by a late consumer
- id_early_rs, id_early_rt  in  1 each  operand needed in ID (branch/JR)
- id_rdata_rs, id_rdata_rt  in  XLEN each  regfile read data
- fwd_dest  in  NFWD*5  destination register per stage (stage i at [5i+4:5i])
- fwd_wen  in  NFWD  stage i will write its destination
- fwd_ready  in  NFWD  stage i result is valid now (0 for a load before MEM completes)
- fwd_data  in  NFWD*XLEN  stage i result
- id_hilo_access  in  1  MFHI/MFLO/MTHI/MTLO in ID
- id_mdu_start  in  1  MULT/MULTU/DIV/DIVU in ID
- mdu_done  in  1  MDU completion pulse (used when MDU_LAT=0)
- stall  out  1  hold IF/ID, bubble into EX
- rs_val, rt_val  out  XLEN each  forwarded operand values
- rs_fwd_sel, rt_fwd_sel  out  SELW each  0 = regfile, i+1 = stage i
- mdu_busy  out  1  MDU operation in flight
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Match rule: stage i matches source s when fwd_wen[i], fwd_dest[i] == s and s != 0. The lowest matching index (youngest) wins. Register 0 never forwards; rs_val = id_rdata_rs when id_rs = 0.
- Forward select: sel = winner+1 if the winner is ready, otherwise 0. rs_val/rt_val mux the selected data. Fully combinational, zero latency.
- Operand stall for an early source: the winner exists and is not ready.
- Operand stall for a late source: the winner exists, is not ready, and winner index < LATE_SLACK. A late source that is also early uses the early rule.
- MDU FSM, states IDLE and BUSY:
  - Start accepted when id_valid & id_mdu_start & ~stall & ~flush and state is IDLE. Next state BUSY; counter loaded with MDU_LAT-1.
  - BUSY with MDU_LAT>0: counter decrements each cycle; at 0 return to IDLE. mdu_busy is high for exactly MDU_LAT cycles.
  - BUSY with MDU_LAT=0: return to IDLE the cycle after mdu_done is sampled high. mdu_done while IDLE is ignored.
  - mdu_busy = (state == BUSY), registered.
- MDU stall: mdu_busy & id_valid & (id_hilo_access | id_mdu_start).
- stall = id_valid & ~flush & (operand stall | MDU stall). Flush forces stall = 0 and blocks a new MDU start. A flush does not abort an in-flight MDU operation.
- stall_cnt increments when stall = 1 and saturates at 32'hFFFF_FFFF.
- Reset: state IDLE, counter 0, mdu_busy 0, stall_cnt 0. Reset mid-operation returns to IDLE immediately. Combinational outputs follow their inputs during reset.

Decomposition:
- Shared package: the SELW sel encoding constants (SEL_RF = 0), MDU state encoding, and REG_ZERO.
- One sub-module, hazard_src_match: per-source priority match, select generation and data mux. Instantiated twice (rs, rt).
- The MDU FSM and stall_cnt live in the top module.

Test Plan:
- id_rs=5, id_early_rs=1; stage0 dest5, wen=1, ready=0 -> stall=1, rs_fwd_sel=0. Next cycle ready=1, data 0x1234 -> stall=0, rs_fwd_sel=1, rs_val=0x1234.
- id_rt=7, late only; stage0 dest7 not ready -> stall=1. Same producer moved to stage1 not ready (LATE_SLACK=1) -> stall=0.
- Stages 0 and 2 both write r9 with data 0xA and 0xC, both ready -> rt_fwd_sel=1, rt_val=0xA. id_rt=0 with any stage dest 0 -> rt_val=id_rdata_rt, sel=0.
- MDU_LAT=4: start accepted at cycle t -> mdu_busy high for t+1..t+4; MFLO in ID at t+2 -> stall=1. At t+5 -> stall=0.
- MDU_LAT=0: start, mdu_done at t+10 -> mdu_busy falls at t+11. Flush at t+3 with MTHI in ID -> stall=0, mdu_busy stays 1.
- reset asserted while BUSY -> mdu_busy=0 and stall_cnt=0 next cycle. stall_cnt preset near saturation and 3 more stalled cycles -> holds 0xFFFF_FFFF.
